// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction store.
// Instructions keyed on the switches are committed one per button press into
// a small RAM while in LOAD mode; the CPU controller reads them back in IDLE
// through a combinational, 1-based line port.
// Optional feature macro: PROG_CHECKSUM_EN (running XOR of accepted writes).
//
// Commit protocol: wr_btn is a debounced level. A write is requested only on
// its rising edge (wr_pulse, exactly one cycle per press) and is accepted only
// in LOAD with room left; a request while full sets the sticky overflow flag.
module program_loader #(
  parameter int              DEPTH         = 16,
  parameter int              AW            = 4,
  parameter logic [7:0]      DEFAULT_INSTR = 8'b01110000
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_en,
  input  logic          wr_btn,
  input  logic [7:0]    instr_in,
  input  logic [9:0]    rd_addr,
  output logic [7:0]    instr_out,
  output logic [AW:0]   prog_len,
  output logic          loading,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    checksum,
  output logic          state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [AW:0]   FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic            overflow_q, overflow_d;
  logic            btn_q;
  logic            wr_pulse;
  logic            mem_we;
  logic [7:0]      mem_q [DEPTH];
  logic            rd_hit;
  logic [AW-1:0]   rd_idx;

  assign wr_pulse = wr_btn & ~btn_q;

  // Button history; tracks in every state so a held button never fires on LOAD entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) btn_q <= 1'b0;
    else      btn_q <= wr_btn;
  end

  // Control state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state: LOAD entry clears the program; writes only in LOAD; a write on
  // the same edge load_en falls is still accepted.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          overflow_d = 1'b0;
        end
      end
      LOAD: begin
        if (wr_pulse) begin
          if (prog_len_q < FULL_LEN) begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + 1'b1;
            // Pointer saturates on the last slot instead of wrapping.
            if (wr_ptr_q != LAST_PTR) wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!load_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction RAM; contents are unreachable while prog_len is zero, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= instr_in;
  end

`ifdef PROG_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  // Running XOR of accepted words; cleared on LOAD entry, held in IDLE.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && load_en) checksum_d = 8'h00;
    else if (mem_we)                checksum_d = checksum_q ^ instr_in;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) checksum_q <= 8'h00;
    else      checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  // Read port: lines are 1-based; anything not holding a stored word, and the
  // whole LOAD state, returns the default STORE-to-LEDs instruction.
  assign rd_idx = AW'(rd_addr - 10'd1);
  assign rd_hit = (state_q == IDLE) && (rd_addr != 10'd0) &&
                  (rd_addr <= 10'(prog_len_q));

  always_comb begin
    instr_out = DEFAULT_INSTR;
    if (rd_hit) instr_out = mem_q[rd_idx];
  end

  assign prog_len  = prog_len_q;
  assign loading   = (state_q == LOAD);
  assign full      = (prog_len_q == FULL_LEN);
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule
